// File: rtl/count_wrap_monitor_if.sv
// Bundles the counter sample and clear inputs with the lock/wrap/error status
// that count_wrap_monitor reports.
interface count_wrap_monitor_if #(
    parameter int WIDTH      = 4,
    parameter int WRAP_CNT_W = 8
);
    logic [WIDTH-1:0]      count_in;
    logic                  clear;
    logic                  locked;
    logic                  wrap_pulse;
    logic [WRAP_CNT_W-1:0] wrap_count;
    logic                  step_err;

    modport master (
        output count_in, clear,
        input  locked, wrap_pulse, wrap_count, step_err
    );

    modport slave (
        input  count_in, clear,
        output locked, wrap_pulse, wrap_count, step_err
    );
endinterface

// File: rtl/count_wrap_monitor.sv
// Checks that a free-running down counter decrements by one every clock, locks
// after LOCK_N good steps, and reports wrap events and sticky sequence errors.
module count_wrap_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_N     = 4,
    parameter int WRAP_CNT_W = 8,
    parameter int ALLOW_HOLD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    count_wrap_monitor_if.slave  bus
);

    typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;

    localparam int              RUN_W   = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_N);

    state_t                state, state_n;
    logic [WIDTH-1:0]      prev, prev_n, exp_val;
    logic [RUN_W-1:0]      run, run_n;
    logic                  locked_n, pulse_n, err_n;
    logic [WRAP_CNT_W-1:0] wcnt_n;
    logic                  good, hold, bad, wrap;

    function automatic logic [WRAP_CNT_W-1:0] sat_inc(input logic [WRAP_CNT_W-1:0] v);
        return (v == '1) ? v : v + WRAP_CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ACQUIRE;
            prev           <= '0;
            run            <= '0;
            bus.locked     <= 1'b0;
            bus.wrap_pulse <= 1'b0;
            bus.wrap_count <= '0;
            bus.step_err   <= 1'b0;
        end else begin
            state          <= state_n;
            prev           <= prev_n;
            run            <= run_n;
            bus.locked     <= locked_n;
            bus.wrap_pulse <= pulse_n;
            bus.wrap_count <= wcnt_n;
            bus.step_err   <= err_n;
        end
    end

    always_comb begin
        exp_val  = prev - WIDTH'(1);
        good     = (state != ACQUIRE) && (bus.count_in == exp_val);
        hold     = (state != ACQUIRE) && (ALLOW_HOLD != 0) && (bus.count_in == prev);
        bad      = (state != ACQUIRE) && !good && !hold;
        wrap     = good && (prev == '0);

        state_n  = state;
        prev_n   = bus.count_in;
        run_n    = run;
        locked_n = bus.locked;
        pulse_n  = wrap;
        wcnt_n   = bus.wrap_count;
        err_n    = bus.step_err;

        if (wrap)
            wcnt_n = sat_inc(bus.wrap_count);
        // Clear is applied before the error set below so a same-edge bad step wins.
        if (bus.clear) begin
            wcnt_n = '0;
            err_n  = 1'b0;
        end

        unique case (state)
            ACQUIRE: begin
                state_n = TRACK;
                run_n   = '0;
            end
            TRACK: begin
                if (good) begin
                    if (run == RUN_MAX - RUN_W'(1)) begin
                        state_n  = LOCKED;
                        locked_n = 1'b1;
                        run_n    = RUN_MAX;
                    end else begin
                        run_n = run + RUN_W'(1);
                    end
                end else if (bad) begin
                    run_n = '0;
                end
            end
            LOCKED: begin
                if (bad) begin
                    state_n  = TRACK;
                    locked_n = 1'b0;
                    run_n    = '0;
                    err_n    = 1'b1;
                end
            end
            default: state_n = ACQUIRE;
        endcase
    end

endmodule
